grf_wport_arbiter: RTL and testbench
====================================

// Module: grf_wport_arbiter
// PURPOSE
//  Shares the single GRF write port (WE/A3/WD/PC) between two writers:
//  - A: the pipeline W stage, which has priority and no backpressure.
//  - B: the multi-cycle MDU/late-result path, which uses a valid/ready handshake.
//  B results are buffered in a small FIFO and drained on cycles when A is idle.
//  Also drives the hazard unit: a D-stage stall while a pending B write targets
//  a D read register, and a pipeline hold on full-FIFO or starvation.
// PARAMETERS
//  DEPTH       2   B FIFO entries (power of 2, >=2)
//  STARVE_MAX  8   cycles a live FIFO head may wait before a_hold is forced
// PORTS
//  clk       in   1   system clock, all state on posedge
//  reset     in   1   asynchronous, active-high; clears all state
//  a_we      in   1   W-stage write enable
//  a_addr    in   5   W-stage destination register
//  a_wd      in   32  W-stage write data
//  a_pc      in   32  W-stage PC (for the write log)
//  b_valid   in   1   MDU result valid
//  b_ready   out  1   FIFO can accept; equals !full
//  b_addr    in   5   MDU destination register
//  b_wd      in   32  MDU result
//  b_pc      in   32  PC of the MDU instruction
//  rd_a1     in   5   D-stage read address 1
//  rd_a2     in   5   D-stage read address 2
//  rd_stall  out  1   D-stage read hits a pending B write
//  a_hold    out  1   freeze pipeline; A must present a_we=0 while this is high
//  grf_we    out  1   GRF WE
//  grf_a3    out  5   GRF A3
//  grf_wd    out  32  GRF WD
//  grf_pc    out  32  GRF PC
// BEHAVIOUR
//  - Reset: FIFO empty; all entries dead; wait counter 0; FSM in RUN.
//    Outputs after reset: b_ready=1, rd_stall=0, a_hold=0, grf_we=0, grf_a3/wd/pc=0.
//  - Address 0: A writes with a_addr==0 are ignored. A B handshake with b_addr==0
//    is accepted (ready/valid) but not stored.
//  - Write port (combinational):
//    - If a_we && a_addr!=0, A drives grf_*.
//    - Else if the FIFO is non-empty, the head drives grf_*, with grf_we=head.live;
//      the head pops this cycle, live or dead.
//    - Else grf_we=0 and grf_a3/wd/pc=0.
//  - B path: push on b_valid && b_ready, with no bypass, so minimum B->GRF
//    latency is 1 cycle. A pop and a push in the same cycle are both allowed.
//    When full, b_ready=0 even if a pop is occurring.
//  - Kill rule: an A write to X clears live on every stored entry with addr==X
//    (the B result is older than A). A same-cycle B push to X with A writing X
//    is stored live (B is younger).
//  - rd_stall = OR over live entries, and over the pushing B beat, of
//    (addr!=0 && (addr==rd_a1 || addr==rd_a2)).
//  - FSM, 2 states:
//    - RUN->DRAIN when the FIFO is full, or the wait counter reaches STARVE_MAX.
//    - DRAIN->RUN when the FIFO is empty.
//    - a_hold = (state==DRAIN).
//    - An A write arriving during DRAIN still has priority: the violation is not
//      masked, and a simulation $display warning is printed.
//  - Wait counter: increments while the head is live and A owns the port;
//    clears on pop; saturates at STARVE_MAX.
//  - Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
//  - Reset mid-drain: FIFO contents are discarded and no GRF write is issued.
// STRUCTURE
//  - grf_defs.vh: `define REG_W 5, `DATA_W 32, FSM state codes RUN/DRAIN.
//  - Sub-module grf_wb_fifo: storage, pointers, count, per-entry live bits,
//    kill port, and address-match outputs. The top level holds the arbitration,
//    FSM and counter.
// TESTING
//  1. Reset high mid-operation, then release -> b_ready=1, grf_we=0, a_hold=0,
//     rd_stall=0 immediately.
//  2. b push {addr=5, wd=0x1234} with A idle -> next cycle grf_we=1, a3=5,
//     wd=0x1234; FIFO empty after.
//  3. A writes $3 every cycle; B pushes to $7, $8 -> b_ready=0 after 2 pushes
//     and a_hold=1. A drops we -> $7 then $8 written in order, then a_hold=0.
//  4. B pushes $9 (A busy); next cycle A writes $9=0xAA -> popped head gives
//     grf_we=0; GRF keeps 0xAA.
//  5. Entry $4 pending, rd_a2=4 -> rd_stall=1 until the cycle after the pop.
//     b_addr=0 push -> no stall and no write.
//  6. A busy for 8 cycles with one live entry -> a_hold rises in cycle 9;
//     drain; then RUN.

Source files
------------

// File: rtl/grf_wport_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// grf_wport_arbiter_pkg
//   Shared widths, FSM state type, the buffered write-beat record and a small
//   register-hit helper. Both the write-back FIFO and the arbiter top use it.
// ----------------------------------------------------------------------------
package grf_wport_arbiter_pkg;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned DATA_W = 32;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } arb_state_e;

   // One buffered late-result write.
   typedef struct packed {
      logic [REG_W-1:0]  addr;
      logic [DATA_W-1:0] wd;
      logic [DATA_W-1:0] pc;
   } wb_beat_t;

   // $0 never creates a dependency, so it never hits.
   function automatic logic reg_hit(input logic [REG_W-1:0] addr,
                                    input logic [REG_W-1:0] a1,
                                    input logic [REG_W-1:0] a2);
      return (addr != '0) && ((addr == a1) || (addr == a2));
   endfunction

endpackage

// File: rtl/grf_wb_fifo.sv
// ----------------------------------------------------------------------------
// grf_wb_fifo
//   Small circular buffer for late (MDU) GRF writes. Each entry carries a live
//   bit; a younger pipeline write to the same register kills older entries so
//   they drain without touching the GRF.
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   push_i/beat_i     store a beat at the tail (caller guarantees !full)
//   pop_i             drop the head (caller guarantees !empty)
//   kill_i/addr_i     clear live on every stored entry with a matching addr
//   rd_a1_i, rd_a2_i  D-stage read addresses
//   empty_o, full_o   occupancy flags
//   head_o/live_o     head entry and its live bit
//   rd_hit_o          some live entry targets a D-stage read register
// ----------------------------------------------------------------------------
module grf_wb_fifo
   import grf_wport_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  wb_beat_t         push_beat_i,
   input  logic             pop_i,
   input  logic             kill_i,
   input  logic [REG_W-1:0] kill_addr_i,
   input  logic [REG_W-1:0] rd_a1_i,
   input  logic [REG_W-1:0] rd_a2_i,
   output logic             empty_o,
   output logic             full_o,
   output wb_beat_t         head_o,
   output logic             head_live_o,
   output logic             rd_hit_o
);

   localparam int unsigned    PTR_W    = $clog2(DEPTH);
   localparam int unsigned    CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   wb_beat_t         mem_q [DEPTH];
   logic [DEPTH-1:0] live_q,   live_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   assign empty_o     = (count_q == '0);
   assign full_o      = (count_q == FULL_CNT);
   assign head_o      = mem_q[rd_ptr_q];
   // Live bits are only ever set on occupied slots, so an empty FIFO reads 0.
   assign head_live_o = live_q[rd_ptr_q];

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      live_d   = live_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      // Kill first: an entry pushed this cycle is younger and must stay live.
      if (kill_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (mem_q[i].addr == kill_addr_i) live_d[i] = 1'b0;
         end
      end
      if (pop_i) begin
         live_d[rd_ptr_q] = 1'b0;
         rd_ptr_d         = rd_ptr_q + PTR_W'(1);
      end
      if (push_i) begin
         live_d[wr_ptr_q] = 1'b1;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end

      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      rd_hit_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live_q[i] && reg_hit(mem_q[i].addr, rd_a1_i, rd_a2_i)) rd_hit_o = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         live_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         live_q   <= live_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the payload array is deliberately not reset; count and live bits
   // gate every use of it, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_beat_i;
   end

endmodule

// File: rtl/grf_wport_arbiter.sv
// ----------------------------------------------------------------------------
// grf_wport_arbiter
//   Shares the single GRF write port between the W stage (A, priority, no
//   backpressure) and the late MDU result path (B, valid/ready). B beats are
//   buffered and drained on cycles when A is idle. Also raises a D-stage
//   read stall on pending B writes and a pipeline hold on a full buffer or a
//   starved head.
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   a_we/a_addr/a_wd/a_pc      W-stage write
//   b_valid/b_ready            MDU handshake (b_ready = !full)
//   b_addr/b_wd/b_pc           MDU write beat
//   rd_a1, rd_a2               D-stage read addresses
//   rd_stall                   D-stage read hits a pending B write
//   a_hold                     freeze pipeline while the buffer drains
//   grf_we/grf_a3/grf_wd/grf_pc GRF write port
// ----------------------------------------------------------------------------
module grf_wport_arbiter
   import grf_wport_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_we,
   input  logic [REG_W-1:0]  a_addr,
   input  logic [DATA_W-1:0] a_wd,
   input  logic [DATA_W-1:0] a_pc,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [REG_W-1:0]  b_addr,
   input  logic [DATA_W-1:0] b_wd,
   input  logic [DATA_W-1:0] b_pc,
   input  logic [REG_W-1:0]  rd_a1,
   input  logic [REG_W-1:0]  rd_a2,
   output logic              rd_stall,
   output logic              a_hold,
   output logic              grf_we,
   output logic [REG_W-1:0]  grf_a3,
   output logic [DATA_W-1:0] grf_wd,
   output logic [DATA_W-1:0] grf_pc
);

   localparam int unsigned      WAIT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_MAX);

   arb_state_e        state_q, state_d;
   logic [WAIT_W-1:0] wait_q,  wait_d;

   logic     a_wr;
   logic     b_push_hs;
   logic     b_store;
   logic     fifo_pop;
   logic     fifo_empty;
   logic     fifo_full;
   logic     head_live;
   logic     fifo_rd_hit;
   wb_beat_t head;
   wb_beat_t b_beat;

   assign a_wr      = a_we && (a_addr != '0);
   assign b_ready   = !fifo_full;
   assign b_push_hs = b_valid && b_ready;
   // A $0 beat completes its handshake but has nothing to write.
   assign b_store   = b_push_hs && (b_addr != '0);
   assign fifo_pop  = !a_wr && !fifo_empty;
   assign b_beat    = '{addr: b_addr, wd: b_wd, pc: b_pc};

   grf_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (b_store),
      .push_beat_i (b_beat),
      .pop_i       (fifo_pop),
      .kill_i      (a_wr),
      .kill_addr_i (a_addr),
      .rd_a1_i     (rd_a1),
      .rd_a2_i     (rd_a2),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full),
      .head_o      (head),
      .head_live_o (head_live),
      .rd_hit_o    (fifo_rd_hit)
   );

   // Write-port mux: A wins; otherwise the head drains, dead heads with we=0.
   always_comb begin
      grf_we = 1'b0;
      grf_a3 = '0;
      grf_wd = '0;
      grf_pc = '0;
      if (a_wr) begin
         grf_we = 1'b1;
         grf_a3 = a_addr;
         grf_wd = a_wd;
         grf_pc = a_pc;
      end else if (!fifo_empty) begin
         grf_we = head_live;
         grf_a3 = head.addr;
         grf_wd = head.wd;
         grf_pc = head.pc;
      end
   end

   // No bypass, so the beat being pushed is not yet in the FIFO and is
   // checked separately.
   assign rd_stall = fifo_rd_hit || (b_store && reg_hit(b_addr, rd_a1, rd_a2));

   // Starvation counter: counts cycles a live head loses the port to A.
   always_comb begin
      wait_d = wait_q;
      if (fifo_pop) begin
         wait_d = '0;
      end else if (a_wr && !fifo_empty && head_live && (wait_q != WAIT_MAX)) begin
         wait_d = wait_q + WAIT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN:   if (fifo_full || (wait_q == WAIT_MAX)) state_d = ST_DRAIN;
         ST_DRAIN: if (fifo_empty) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   assign a_hold = (state_q == ST_DRAIN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

`ifndef SYNTHESIS
   // A write during a hold still takes the port; flag the protocol breach.
   always_ff @(posedge clk) begin
      if (!reset && a_hold && a_wr) begin
         $warning("grf_wport_arbiter: A write to $%0d while a_hold is high", a_addr);
      end
   end
`endif

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// ----------------------------------------------------------------------------
// tb_grf_wport_arbiter
//   Directed scenarios followed by random traffic, checked every cycle against
//   a queue-based model of the buffered write port.
// ----------------------------------------------------------------------------
module tb_grf_wport_arbiter;

   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 8;

   logic        clk;
   logic        reset;
   logic        a_we;
   logic [4:0]  a_addr;
   logic [31:0] a_wd;
   logic [31:0] a_pc;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_addr;
   logic [31:0] b_wd;
   logic [31:0] b_pc;
   logic [4:0]  rd_a1;
   logic [4:0]  rd_a2;
   logic        rd_stall;
   logic        a_hold;
   logic        grf_we;
   logic [4:0]  grf_a3;
   logic [31:0] grf_wd;
   logic [31:0] grf_pc;

   grf_wport_arbiter #(
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .a_we     (a_we),
      .a_addr   (a_addr),
      .a_wd     (a_wd),
      .a_pc     (a_pc),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_addr   (b_addr),
      .b_wd     (b_wd),
      .b_pc     (b_pc),
      .rd_a1    (rd_a1),
      .rd_a2    (rd_a2),
      .rd_stall (rd_stall),
      .a_hold   (a_hold),
      .grf_we   (grf_we),
      .grf_a3   (grf_a3),
      .grf_wd   (grf_wd),
      .grf_pc   (grf_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pending B writes in age order, hold flag, wait count.
   typedef struct {
      logic [4:0]  addr;
      logic [31:0] wd;
      logic [31:0] pc;
      bit          live;
   } ent_t;

   ent_t q[$];
   bit   m_hold;
   int   m_wait;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit hits(input logic [4:0] addr);
      return (addr != 5'd0) && ((addr == rd_a1) || (addr == rd_a2));
   endfunction

   task automatic drive_a(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                          input logic [31:0] pc);
      a_we = we; a_addr = addr; a_wd = wd; a_pc = pc;
   endtask

   task automatic drive_b(input logic v, input logic [4:0] addr, input logic [31:0] wd,
                          input logic [31:0] pc);
      b_valid = v; b_addr = addr; b_wd = wd; b_pc = pc;
   endtask

   task automatic drive_rd(input logic [4:0] r1, input logic [4:0] r2);
      rd_a1 = r1; rd_a2 = r2;
   endtask

   // Called at posedge+1 with inputs applied; compares outputs mid-cycle.
   task automatic eval_and_check();
      bit          a_wr;
      bit          full;
      bit          push;
      bit          e_we;
      logic [4:0]  e_a3;
      logic [31:0] e_wd;
      logic [31:0] e_pc;
      bit          e_stall;
      #3;
      a_wr = a_we && (a_addr != 5'd0);
      full = (q.size() == DEPTH);
      push = b_valid && !full;
      e_we = 1'b0; e_a3 = 5'd0; e_wd = 32'd0; e_pc = 32'd0;
      if (a_wr) begin
         e_we = 1'b1; e_a3 = a_addr; e_wd = a_wd; e_pc = a_pc;
      end else if (q.size() > 0) begin
         e_we = q[0].live; e_a3 = q[0].addr; e_wd = q[0].wd; e_pc = q[0].pc;
      end
      e_stall = 1'b0;
      foreach (q[i]) if (q[i].live && hits(q[i].addr)) e_stall = 1'b1;
      if (push && hits(b_addr)) e_stall = 1'b1;
      check("b_ready",  32'(b_ready),  32'(!full));
      check("a_hold",   32'(a_hold),   32'(m_hold));
      check("rd_stall", 32'(rd_stall), 32'(e_stall));
      check("grf_we",   32'(grf_we),   32'(e_we));
      check("grf_a3",   32'(grf_a3),   32'(e_a3));
      check("grf_wd",   grf_wd,        e_wd);
      check("grf_pc",   grf_pc,        e_pc);
   endtask

   // Advance the model across the coming clock edge, then move to posedge+1.
   task automatic tick();
      bit a_wr;
      bit full;
      bit head_live;
      bit do_pop;
      bit nh;
      int nw;
      a_wr      = a_we && (a_addr != 5'd0);
      full      = (q.size() == DEPTH);
      head_live = (q.size() > 0) && q[0].live;
      do_pop    = !a_wr && (q.size() > 0);
      nh = m_hold ? (q.size() != 0) : (full || (m_wait == STARVE_MAX));
      nw = m_wait;
      if (do_pop) nw = 0;
      else if (a_wr && head_live && (m_wait < STARVE_MAX)) nw = m_wait + 1;
      if (a_wr) foreach (q[i]) if (q[i].addr == a_addr) q[i].live = 1'b0;
      if (do_pop) void'(q.pop_front());
      if (b_valid && !full && (b_addr != 5'd0))
         q.push_back('{addr: b_addr, wd: b_wd, pc: b_pc, live: 1'b1});
      m_hold = nh;
      m_wait = nw;
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      eval_and_check();
      tick();
   endtask

   task automatic check_reset_outputs();
      check("rst_b_ready",  32'(b_ready),  32'd1);
      check("rst_rd_stall", 32'(rd_stall), 32'd0);
      check("rst_a_hold",   32'(a_hold),   32'd0);
      check("rst_grf_we",   32'(grf_we),   32'd0);
      check("rst_grf_a3",   32'(grf_a3),   32'd0);
      check("rst_grf_wd",   grf_wd,        32'd0);
      check("rst_grf_pc",   grf_pc,        32'd0);
   endtask

   // Asynchronous reset between edges; outputs must clear at once.
   task automatic do_reset();
      drive_a(1'b0, 5'd0, 32'd0, 32'd0);
      drive_b(1'b0, 5'd0, 32'd0, 32'd0);
      drive_rd(5'd0, 5'd0);
      reset = 1'b1;
      #1;
      q.delete();
      m_hold = 1'b0;
      m_wait = 0;
      check_reset_outputs();
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      drive_a(1'b0, 5'd0, 32'd0, 32'd0);
      drive_b(1'b0, 5'd0, 32'd0, 32'd0);
      drive_rd(5'd0, 5'd0);
      m_hold = 1'b0;
      m_wait = 0;
      @(posedge clk);
      #1;
      do_reset();

      // B push with A idle: written one cycle later, then FIFO empty.
      drive_b(1'b1, 5'd5, 32'h1234, 32'h100);
      step();
      drive_b(1'b0, 5'd0, 32'd0, 32'd0);
      eval_and_check();
      check("t2_we", 32'(grf_we), 32'd1);
      check("t2_a3", 32'(grf_a3), 32'd5);
      check("t2_wd", grf_wd, 32'h1234);
      tick();
      eval_and_check();
      check("t2_empty_we", 32'(grf_we), 32'd0);
      tick();

      // A busy on $3 while B fills the FIFO; hold, then in-order drain.
      for (int i = 0; i < 4; i++) begin
         drive_a(!m_hold, 5'd3, 32'h300 + i, 32'h400 + i);
         drive_b(i < 2, (i == 0) ? 5'd7 : 5'd8, 32'h700 + i, 32'h800 + i);
         step();
      end
      drive_b(1'b0, 5'd0, 32'd0, 32'd0);
      for (int i = 0; i < 5; i++) begin
         drive_a(!m_hold, 5'd3, 32'h310 + i, 32'h410 + i);
         if (m_hold) drive_a(1'b0, 5'd0, 32'd0, 32'd0);
         step();
      end

      // Refill to a drain, then reset in the middle of it.
      for (int i = 0; i < 3; i++) begin
         drive_a(!m_hold, 5'd3, 32'h320 + i, 32'h420);
         drive_b(i < 2, 5'd11 + 5'(i), 32'hB00 + i, 32'hC00 + i);
         step();
      end
      do_reset();

      // Older B write to $9 is killed by a younger A write to $9.
      drive_a(1'b1, 5'd3, 32'h33, 32'h500);
      drive_b(1'b1, 5'd9, 32'h99, 32'h504);
      step();
      drive_a(1'b1, 5'd9, 32'hAA, 32'h508);
      drive_b(1'b0, 5'd0, 32'd0, 32'd0);
      step();
      drive_a(1'b0, 5'd0, 32'd0, 32'd0);
      eval_and_check();
      check("t4_dead_we", 32'(grf_we), 32'd0);
      check("t4_dead_a3", 32'(grf_a3), 32'd9);
      tick();

      // Pending $4 against rd_a2=4, then a $0 beat.
      drive_rd(5'd0, 5'd4);
      drive_a(1'b1, 5'd3, 32'h44, 32'h600);
      drive_b(1'b1, 5'd4, 32'h4444, 32'h604);
      eval_and_check();
      check("t5_push_stall", 32'(rd_stall), 32'd1);
      tick();
      drive_b(1'b0, 5'd0, 32'd0, 32'd0);
      step();
      drive_a(1'b0, 5'd0, 32'd0, 32'd0);
      eval_and_check();
      check("t5_pop_stall", 32'(rd_stall), 32'd1);
      tick();
      eval_and_check();
      check("t5_after_stall", 32'(rd_stall), 32'd0);
      tick();
      drive_rd(5'd0, 5'd0);
      drive_b(1'b1, 5'd0, 32'h55, 32'h610);
      eval_and_check();
      check("t5_zero_stall", 32'(rd_stall), 32'd0);
      tick();
      drive_b(1'b0, 5'd0, 32'd0, 32'd0);
      eval_and_check();
      check("t5_zero_we", 32'(grf_we), 32'd0);
      tick();

      // Starvation: one live entry, A busy until the hold forces a drain.
      drive_a(1'b1, 5'd3, 32'h66, 32'h700);
      drive_b(1'b1, 5'd10, 32'hA0A0, 32'h704);
      step();
      drive_b(1'b0, 5'd0, 32'd0, 32'd0);
      for (int i = 0; i < 14; i++) begin
         drive_a(!m_hold, 5'd3, 32'h670 + i, 32'h710 + i);
         if (m_hold) drive_a(1'b0, 5'd0, 32'd0, 32'd0);
         step();
      end

      // Random traffic; A respects the hold.
      for (int n = 0; n < 600; n++) begin
         if (m_hold) drive_a(1'b0, 5'($urandom_range(0, 7)), $urandom, $urandom);
         else drive_a(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom, $urandom);
         drive_b(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom, $urandom);
         drive_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
